// File: rtl/cpu_host_loader_if.sv
// Host-side load/dump stream bundle for cpu_host_loader.
// Ports (signals): in_valid/in_data/in_ready carry the load
// stream toward the loader; out_valid/out_data/out_last/out_ready
// carry the dump stream back to the host.
// master = host side, slave = loader side.
interface cpu_host_loader_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/cpu_host_loader.sv
// Host-side loader: streams program/data words into the CPU
// memories under reset, runs the CPU, then dumps a data window.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a session (IDLE/DONE only)
//   prog_len, data_len  words to load (clamped to 1024)
//   dump_base, dump_len readback window (address wraps)
//   host                load/dump valid-ready streams (slave)
//   cpu_*               CPU reset and memory write/read port
//   busy, finished      session status
//   timed_out           run ended by MAX_CYCLES
//   cycle_count         RUN cycles seen with cpu_done=0
module cpu_host_loader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic [ADDR_W:0]   data_len,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    cpu_host_loader_if.slave  host,
    output logic              cpu_rst,
    output logic              cpu_we_ins,
    output logic [ADDR_W-1:0] cpu_add_ins,
    output logic [DATA_W-1:0] cpu_input_ins,
    output logic              cpu_we_data,
    output logic [ADDR_W-1:0] cpu_add_data,
    output logic [DATA_W-1:0] cpu_input_data,
    input  logic [DATA_W-1:0] cpu_out,
    input  logic              cpu_done,
    output logic              busy,
    output logic              finished,
    output logic              timed_out,
    output logic [31:0]       cycle_count
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_INS,
        S_LOAD_DATA,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t          state;
    logic            wr_flush;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] p_len;
    logic [ADDR_W:0] d_len;
    logic [ADDR_W:0] u_len;
    logic [ADDR_W-1:0] base;

    function automatic logic [ADDR_W:0] clamp_len(
        input logic [ADDR_W:0] v
    );
        return (v > DEPTH) ? DEPTH : v;
    endfunction

    logic loading;
    logic dumping;
    logic in_hs;
    logic out_hs;
    logic ins_last;
    logic dat_last;
    logic dmp_last;

    assign loading  = (state == S_LOAD_INS) ||
                      (state == S_LOAD_DATA);
    assign dumping  = (state == S_DUMP);

    // Ready drops while the last load write drains, so the
    // CPU stays in reset for the full final write pulse.
    assign host.in_ready  = loading && !wr_flush;
    assign host.out_valid = dumping;
    assign host.out_data  = dumping ? cpu_out : '0;
    assign host.out_last  = dumping && dmp_last;

    assign in_hs  = host.in_valid && host.in_ready;
    assign out_hs = host.out_valid && host.out_ready;

    assign ins_last = (idx == p_len - 1'b1);
    assign dat_last = (idx == d_len - 1'b1);
    assign dmp_last = (idx == u_len - 1'b1);

    assign cpu_rst  = !((state == S_RUN) || dumping);
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign finished = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wr_flush       <= 1'b0;
            idx            <= '0;
            p_len          <= '0;
            d_len          <= '0;
            u_len          <= '0;
            base           <= '0;
            cycle_count    <= '0;
            timed_out      <= 1'b0;
            cpu_we_ins     <= 1'b0;
            cpu_add_ins    <= '0;
            cpu_input_ins  <= '0;
            cpu_we_data    <= 1'b0;
            cpu_add_data   <= '0;
            cpu_input_data <= '0;
        end else begin
            cpu_we_ins  <= 1'b0;
            cpu_we_data <= 1'b0;
            if (wr_flush) begin
                wr_flush <= 1'b0;
                state    <= S_RUN;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            p_len       <= clamp_len(prog_len);
                            d_len       <= clamp_len(data_len);
                            u_len       <= clamp_len(dump_len);
                            base        <= dump_base;
                            idx         <= '0;
                            cycle_count <= '0;
                            timed_out   <= 1'b0;
                            if (prog_len != '0)
                                state <= S_LOAD_INS;
                            else if (data_len != '0)
                                state <= S_LOAD_DATA;
                            else
                                state <= S_RUN;
                        end
                    end
                    S_LOAD_INS: begin
                        if (in_hs) begin
                            cpu_we_ins    <= 1'b1;
                            cpu_add_ins   <= idx[ADDR_W-1:0];
                            cpu_input_ins <= host.in_data;
                            if (ins_last) begin
                                idx <= '0;
                                if (d_len != '0)
                                    state <= S_LOAD_DATA;
                                else
                                    wr_flush <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    S_LOAD_DATA: begin
                        if (in_hs) begin
                            cpu_we_data    <= 1'b1;
                            cpu_add_data   <= idx[ADDR_W-1:0];
                            cpu_input_data <= host.in_data;
                            if (dat_last) begin
                                idx      <= '0;
                                wr_flush <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (cpu_done) begin
                            idx          <= '0;
                            cpu_add_data <= base;
                            if (u_len != '0)
                                state <= S_DUMP;
                            else
                                state <= S_DONE;
                        end else begin
                            cycle_count <= cycle_count + 32'd1;
                            if (cycle_count ==
                                32'(MAX_CYCLES - 1)) begin
                                timed_out <= 1'b1;
                                state     <= S_DONE;
                            end
                        end
                    end
                    S_DUMP: begin
                        // Address is base+idx; ADDR_W-bit add wraps.
                        if (out_hs) begin
                            if (dmp_last) begin
                                state <= S_DONE;
                            end else begin
                                idx          <= idx + 1'b1;
                                cpu_add_data <= cpu_add_data + 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/cpu_host_loader.md
Name: cpu_host_loader

Overview:
- Host-side initiator for the CPU's memory-load and result-readback port.
- Accepts a program and an initial data image as a valid/ready word stream and writes them into instruction and data memory while holding the CPU in reset.
- Releases the CPU, counts execution cycles until the CPU raises its halt flag or a timeout expires, then streams a window of data memory back out.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words per memory)
- DATA_W, 32, memory word width
- MAX_CYCLES, 100000, RUN cycles allowed before timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a session; sampled only in IDLE or DONE
- prog_len  in  ADDR_W+1  instruction words to load; sampled at start
- data_len  in  ADDR_W+1  data words to load; sampled at start
- dump_base  in  ADDR_W  first data address to read back; sampled at start
- dump_len  in  ADDR_W+1  data words to read back; sampled at start
- in_valid  in  1  load-stream word valid
- in_data  in  DATA_W  load-stream word
- in_ready  out  1  load-stream accept
- out_valid  out  1  dump-stream word valid
- out_data  out  DATA_W  dump-stream word
- out_last  out  1  final dump word
- out_ready  in  1  dump-stream accept
- cpu_rst  out  1  CPU reset/load-mode enable
- cpu_we_ins  out  1  instruction memory write enable
- cpu_add_ins  out  ADDR_W  instruction memory write address
- cpu_input_ins  out  DATA_W  instruction memory write data
- cpu_we_data  out  1  data memory write enable
- cpu_add_data  out  ADDR_W  data memory write/read address
- cpu_input_data  out  DATA_W  data memory write data
- cpu_out  in  DATA_W  CPU data memory read port (combinational read of cpu_add_data while CPU is halted)
- cpu_done  in  1  CPU halt flag
- busy  out  1  state not IDLE/DONE
- finished  out  1  session complete
- timed_out  out  1  session ended by timeout
- cycle_count  out  32  RUN cycles with cpu_done=0

Behaviour:
- Reset values and reset-mid-session: rst forces the following on the next edge, from any state, and discards any session in progress:
  - state IDLE
  - cpu_rst=1, all enables 0, all addresses and data 0
  - in_ready, out_valid, out_last, busy, finished and timed_out all 0
  - cycle_count 0
- States: IDLE, LOAD_INS, LOAD_DATA, RUN, DUMP, DONE.
- cpu_rst is 0 only in RUN and DUMP; it is 1 elsewhere.
- Start handling:
  - start in IDLE or DONE latches the four length/base inputs and clears finished, timed_out, cycle_count and the index counter.
  - Lengths above 1024 are clamped to 1024.
  - Next state is LOAD_INS if prog_len≠0, else LOAD_DATA if data_len≠0, else RUN.
  - start in any other state is ignored.
- LOAD_INS:
  - in_ready=1 (combinational from state).
  - Each in_valid&in_ready handshake registers cpu_we_ins=1, cpu_add_ins=idx and cpu_input_ins=in_data; the memory write happens on the following edge (one-cycle latency).
  - idx increments on each handshake.
  - On the handshake with idx=prog_len-1: clear idx and go to LOAD_DATA (or RUN if data_len=0).
  - Cycles without a handshake drive cpu_we_ins=0.
- LOAD_DATA: identical to LOAD_INS but drives cpu_we_data, cpu_add_data and cpu_input_data; exits to RUN.
- The registered write pulse from the final load word is still issued while entering the next state; cpu_rst stays 1 during that pulse.
- RUN:
  - in_ready=0, cpu_rst=0.
  - Each cycle with cpu_done=0 increments cycle_count.
  - cpu_done=1 in any cycle, including the first, moves to DUMP (or DONE if dump_len=0); cycle_count is not incremented in that cycle.
  - If cycle_count reaches MAX_CYCLES with cpu_done=0: set timed_out=1 and go to DONE, skipping DUMP.
- DUMP:
  - cpu_add_data is registered and equals (dump_base+idx) mod 2^ADDR_W, so the address wraps.
  - out_valid=1; out_data=cpu_out (combinational pass-through); out_last=(idx==dump_len-1).
  - On out_valid&out_ready, idx increments and the address advances on the next edge.
  - out_data must be held stable while out_ready=0.
  - After the last handshake go to DONE.
  - cpu_we_data=0 throughout.
- DONE:
  - finished=1, cpu_rst=1.
  - cycle_count and timed_out hold until the next start.
- busy=1 in LOAD_INS, LOAD_DATA, RUN and DUMP.

Test Plan:
- prog_len=3 {A,B,C}, data_len=2 {5,7} with in_valid held high:
  - cpu_we_ins pulses at addresses 0,1,2 with A,B,C; cpu_we_data pulses at 0,1 with 5,7.
  - cpu_rst=1 during every pulse; RUN is entered 1 cycle after the last pulse is registered.
- cpu_done tied high from the first RUN cycle: cycle_count=0 and state goes straight to DUMP.
- cpu_done rises after 25 RUN cycles, dump_base=1022, dump_len=4, out_ready toggling 1/0:
  - cpu_add_data sequence 1022,1023,0,1.
  - out_data is stable across stall cycles; out_last only on the 4th word; finished=1 afterwards.
- MAX_CYCLES=50 with cpu_done held 0: timed_out=1, cycle_count=50, no out_valid, cpu_rst=1.
- prog_len=data_len=dump_len=0: start → RUN → DONE; no write enables, no out_valid.
- rst asserted mid-LOAD_DATA after 1 of 3 words, then start issued again:
  - Next cycle all outputs are at reset values.
  - The new session loads from address 0.
